// File: rtl/tg_mpfifo_wr_sched.sv
// rtl/tg_mpfifo_wr_sched.sv - budget-limited round-robin write scheduler feeding a multiport FIFO
module tg_mpfifo_wr_sched #(
    parameter int TCQ          = 100,
    parameter int WIDTH        = 576,
    parameter int LOG2DEPTH    = 2,
    parameter int NUM_PORT     = 4,
    parameter int LOG2NUM_PORT = 2,
    parameter int MAX_GRANT    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_PORT-1:0]       req_valid,
    input  logic [NUM_PORT*WIDTH-1:0] req_data,
    output logic [NUM_PORT-1:0]       req_ready,
    input  logic [LOG2DEPTH:0]        fifo_space,
    input  logic                      fifo_full,
    output logic [NUM_PORT-1:0]       fifo_wren,
    output logic [NUM_PORT*WIDTH-1:0] fifo_din,
    output logic                      busy
);

    localparam int BW = LOG2DEPTH + 2;

    if (MAX_GRANT < 1 || MAX_GRANT > NUM_PORT || TCQ < 0 || NUM_PORT != (1 << LOG2NUM_PORT)) begin : g_param_check
        $error("tg_mpfifo_wr_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic [LOG2NUM_PORT-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORT-1:0]         wren_q, grant;
    logic [NUM_PORT*WIDTH-1:0]   din_q, din_d;
    logic [BW-1:0]               inflight, slack, budget, gcnt;
    logic [LOG2NUM_PORT-1:0]     idx;

    // Writes issued last cycle are not yet reflected in fifo_space, so they are charged here.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            inflight = inflight + BW'(wren_q[i]);
        end
        slack  = {1'b0, fifo_space} - inflight;
        budget = '0;
        if (state_q == S_RUN && en && !fifo_full && !slack[BW-1]) begin
            budget = (slack > BW'(MAX_GRANT)) ? BW'(MAX_GRANT) : slack;
        end
    end

    // Scan from rr_ptr; the pointer moves past the last port granted in scan order.
    always_comb begin
        grant    = '0;
        gcnt     = '0;
        idx      = '0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < NUM_PORT; k++) begin
            idx = rr_ptr_q + LOG2NUM_PORT'(k);
            if (req_valid[idx] && gcnt < budget) begin
                grant[idx] = 1'b1;
                gcnt       = gcnt + 1'b1;
                rr_ptr_d   = idx + 1'b1;
            end
        end
    end

    always_comb begin
        din_d = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            din_d[i*WIDTH +: WIDTH] = grant[i] ? req_data[i*WIDTH +: WIDTH] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_DRAIN;
            S_DRAIN: if (wren_q == '0) state_d = en ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            wren_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            wren_q   <= grant;
            din_q    <= din_d;
        end
    end

    assign req_ready = grant;
    assign fifo_wren = wren_q;
    assign fifo_din  = din_q;
    assign busy      = (state_q != S_IDLE) || (wren_q != '0);

endmodule

// File: tb/tb_tg_mpfifo_wr_sched.sv
// tb/tb_tg_mpfifo_wr_sched.sv - directed vector bench for tg_mpfifo_wr_sched
module tb_tg_mpfifo_wr_sched;

    localparam int W  = 16;
    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [NP-1:0]   req_valid;
    logic [NP*W-1:0] req_data;
    logic [NP-1:0]   req_ready;
    logic [2:0]      fifo_space;
    logic            fifo_full;
    logic [NP-1:0]   fifo_wren;
    logic [NP*W-1:0] fifo_din;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    tg_mpfifo_wr_sched #(
        .TCQ(100), .WIDTH(W), .LOG2DEPTH(2), .NUM_PORT(NP), .LOG2NUM_PORT(2), .MAX_GRANT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_space(fifo_space), .fifo_full(fifo_full),
        .fifo_wren(fifo_wren), .fifo_din(fifo_din), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [2:0] space;
        logic       full;
        logic [3:0] ready;
        logic       busy;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mask_data(input logic [3:0] g, input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) if (g[i]) r[i*W +: W] = d[i*W +: W];
        return r;
    endfunction

    task automatic drive(input logic e, input logic [3:0] v, input logic [2:0] s, input logic f);
        en         = e;
        req_valid  = v;
        fifo_space = s;
        fifo_full  = f;
        req_data   = {$urandom, $urandom};
    endtask

    logic [3:0] rot_exp [8];
    logic [63:0] held_data;

    initial begin
        // en valid space full | ready busy
        tv[0] = '{1'b1, 4'b1111, 3'd4, 1'b0, 4'b0000, 1'b0};
        tv[1] = '{1'b1, 4'b1111, 3'd4, 1'b0, 4'b1111, 1'b1};
        tv[2] = '{1'b1, 4'b1111, 3'd4, 1'b0, 4'b0000, 1'b1};
        tv[3] = '{1'b1, 4'b1111, 3'd2, 1'b0, 4'b0011, 1'b1};
        tv[4] = '{1'b1, 4'b1111, 3'd2, 1'b0, 4'b0000, 1'b1};
        tv[5] = '{1'b1, 4'b1111, 3'd2, 1'b0, 4'b1100, 1'b1};
        tv[6] = '{1'b1, 4'b1111, 3'd4, 1'b1, 4'b0000, 1'b1};
        tv[7] = '{1'b1, 4'b0101, 3'd1, 1'b0, 4'b0001, 1'b1};
        tv[8] = '{1'b1, 4'b0101, 3'd4, 1'b0, 4'b0101, 1'b1};
        tv[9] = '{1'b1, 4'b1010, 3'd3, 1'b0, 4'b0010, 1'b1};
        rot_exp = '{4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};

        rst_n = 1'b0;
        drive(1'b1, 4'b1111, 3'd4, 1'b0);
        #12;
        chk("reset_wren", 64'(fifo_wren), 64'h0);
        chk("reset_din", fifo_din, 64'h0);
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].en, tv[i].valid, tv[i].space, tv[i].full);
            held_data = req_data;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tv[i].ready));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tv[i].busy));
            tick();
            chk($sformatf("vec%0d_wren", i), 64'(fifo_wren), 64'(tv[i].ready));
            chk($sformatf("vec%0d_din", i), fifo_din, mask_data(tv[i].ready, held_data));
        end

        // Single-slot space with write lag: grants alternate with idle cycles and rotate over every port.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'b1111, 3'd1, 1'b0);
            #1;
            chk($sformatf("rot%0d_ready", i), 64'(req_ready), 64'(rot_exp[i]));
            tick();
        end

        // en falls while a write is in flight: no new grant, one DRAIN cycle, then IDLE.
        drive(1'b1, 4'b0101, 3'd4, 1'b0);
        #1;
        chk("drain_pre_ready", 64'(req_ready), 64'b0101);
        tick();
        chk("drain_pre_wren", 64'(fifo_wren), 64'b0101);
        drive(1'b0, 4'b1111, 3'd4, 1'b0);
        #1;
        chk("drain_en0_ready", 64'(req_ready), 64'h0);
        chk("drain_en0_busy", 64'(busy), 64'h1);
        tick();
        chk("drain_wren", 64'(fifo_wren), 64'h0);
        chk("drain_busy", 64'(busy), 64'h1);
        chk("drain_ready", 64'(req_ready), 64'h0);
        tick();
        chk("idle_busy", 64'(busy), 64'h0);

        // Asynchronous reset while four writes are in flight.
        drive(1'b1, 4'b1111, 3'd4, 1'b0);
        #1;
        chk("rst_seq_idle_ready", 64'(req_ready), 64'h0);
        tick();
        chk("rst_seq_run_ready", 64'(req_ready), 64'b1111);
        tick();
        chk("rst_seq_wren_full", 64'(fifo_wren), 64'b1111);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wren", 64'(fifo_wren), 64'h0);
        chk("async_rst_din", fifo_din, 64'h0);
        chk("async_rst_ready", 64'(req_ready), 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, 3'd2, 1'b0);
        #1;
        chk("post_rst_idle_ready", 64'(req_ready), 64'h0);
        tick();
        chk("post_rst_rr0_ready", 64'(req_ready), 64'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
